// File: rtl/layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// layer_sequencer_if
//   Bundle between the layer sequencer and the accelerator top.
//   The master (sequencer) drives the go pulse, the layer index and the five
//   descriptor fields of the current layer; the slave (accelerator) returns
//   done, which is nonzero once the current layer has completed.
//   Signals:
//     go              1   one-cycle start pulse for the current layer
//     layer_index     3   index of the current layer
//     data_address    32  descriptor fields of the current layer
//     data_size       32
//     weight_address  32
//     weight_size     32
//     result_address  32
//     done            3   accelerator completion, nonzero = complete
// ---------------------------------------------------------------------------
interface layer_sequencer_if;
   logic        go;
   logic [2:0]  layer_index;
   logic [31:0] data_address;
   logic [31:0] data_size;
   logic [31:0] weight_address;
   logic [31:0] weight_size;
   logic [31:0] result_address;
   logic [2:0]  done;

   modport master (
      output go, layer_index, data_address, data_size,
             weight_address, weight_size, result_address,
      input  done
   );

   modport slave (
      input  go, layer_index, data_address, data_size,
             weight_address, weight_size, result_address,
      output done
   );
endinterface

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
//   Runs the accelerator through a multi-layer inference without software
//   involvement per layer. The host programs a descriptor table (addresses and
//   sizes per layer) while idle, then starts a run; the sequencer issues one go
//   pulse per layer in order, waits for done (with a watchdog), waits for done
//   to drop again, and moves on to the next layer.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     i_cfg_we        descriptor write strobe (ignored while busy)
//     i_cfg_layer     descriptor row (ignored if >= MAX_LAYERS)
//     i_cfg_field     0 data_addr,1 data_size,2 weight_addr,3 weight_size,
//                     4 result_addr (others ignored)
//     i_cfg_wdata     descriptor write data
//     i_num_layers    layers to run, sampled when start is accepted
//     i_start         one-cycle run request
//     i_abort         cancel the current run
//     o_busy          high from the cycle after an accepted start until idle
//     o_finished      one-cycle pulse after the last layer
//     o_error         sticky: bad layer count or watchdog expiry
//     o_run_cycles    busy cycles of the last run, saturating
//     acc             accelerator bundle (master side)
// ---------------------------------------------------------------------------
module layer_sequencer #(
   parameter int MAX_LAYERS = 4,
   parameter int TIMEOUT    = 1000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_cfg_we,
   input  logic [2:0]         i_cfg_layer,
   input  logic [2:0]         i_cfg_field,
   input  logic [31:0]        i_cfg_wdata,
   input  logic [2:0]         i_num_layers,
   input  logic               i_start,
   input  logic               i_abort,
   output logic               o_busy,
   output logic               o_finished,
   output logic               o_error,
   output logic [31:0]        o_run_cycles,
   layer_sequencer_if.master  acc
);

   localparam logic [2:0]  LP_MAX_LAYERS = 3'(MAX_LAYERS);
   localparam bit          LP_WDOG_EN    = (TIMEOUT != 0);
   // Counter value on the last permitted WAIT cycle (counter starts at 0).
   localparam logic [31:0] LP_WDOG_LAST  = 32'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_NEXT   = 3'd5,
      ST_FINISH = 3'd6,
      ST_ERROR  = 3'd7
   } state_t;

   state_t      r_state;
   logic [2:0]  r_num_layers;
   logic [2:0]  r_layer;
   logic [31:0] r_wdog;

   // Rows are sized to the full 3-bit index range; only rows below
   // MAX_LAYERS are ever written, so the rest are never used.
   logic [31:0] r_data_addr   [0:7];
   logic [31:0] r_data_size   [0:7];
   logic [31:0] r_weight_addr [0:7];
   logic [31:0] r_weight_size [0:7];
   logic [31:0] r_result_addr [0:7];

   logic w_cfg_ok;
   logic w_num_ok;

   assign w_cfg_ok = i_cfg_we && !o_busy && (i_cfg_layer < LP_MAX_LAYERS)
                     && (i_cfg_field <= 3'd4);
   assign w_num_ok = (i_num_layers != 3'd0) && (i_num_layers <= LP_MAX_LAYERS);

   // Descriptor table: host writes land only while idle and in range; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_cfg_ok) begin
         case (i_cfg_field)
            3'd0:    r_data_addr[i_cfg_layer]   <= i_cfg_wdata;
            3'd1:    r_data_size[i_cfg_layer]   <= i_cfg_wdata;
            3'd2:    r_weight_addr[i_cfg_layer] <= i_cfg_wdata;
            3'd3:    r_weight_size[i_cfg_layer] <= i_cfg_wdata;
            3'd4:    r_result_addr[i_cfg_layer] <= i_cfg_wdata;
            default: ;
         endcase
      end
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state            <= ST_IDLE;
         r_num_layers       <= 3'd0;
         r_layer            <= 3'd0;
         r_wdog             <= 32'd0;
         o_busy             <= 1'b0;
         o_finished         <= 1'b0;
         o_error            <= 1'b0;
         o_run_cycles       <= 32'd0;
         acc.go             <= 1'b0;
         acc.layer_index    <= 3'd0;
         acc.data_address   <= 32'd0;
         acc.data_size      <= 32'd0;
         acc.weight_address <= 32'd0;
         acc.weight_size    <= 32'd0;
         acc.result_address <= 32'd0;
      end else begin
         acc.go     <= 1'b0;
         o_finished <= 1'b0;

         // Every busy cycle counts, including the one in which abort lands.
         if ((r_state != ST_IDLE) && (o_run_cycles != 32'hFFFF_FFFF)) begin
            o_run_cycles <= o_run_cycles + 32'd1;
         end

         if (i_abort && (r_state != ST_IDLE)) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  // abort in the same cycle as start suppresses the run.
                  if (i_start && !i_abort) begin
                     if (w_num_ok) begin
                        r_num_layers <= i_num_layers;
                        r_layer      <= 3'd0;
                        o_error      <= 1'b0;
                        o_run_cycles <= 32'd0;
                        o_busy       <= 1'b1;
                        r_state      <= ST_LOAD;
                     end else begin
                        o_error <= 1'b1;
                     end
                  end
               end
               ST_LOAD: begin
                  acc.layer_index    <= r_layer;
                  acc.data_address   <= r_data_addr[r_layer];
                  acc.data_size      <= r_data_size[r_layer];
                  acc.weight_address <= r_weight_addr[r_layer];
                  acc.weight_size    <= r_weight_size[r_layer];
                  acc.result_address <= r_result_addr[r_layer];
                  acc.go             <= 1'b1;
                  r_state            <= ST_ISSUE;
               end
               ST_ISSUE: begin
                  r_wdog  <= 32'd0;
                  r_state <= ST_WAIT;
               end
               ST_WAIT: begin
                  // done is tested first so it wins over a simultaneous expiry.
                  if (acc.done != 3'd0) begin
                     r_state <= ST_DRAIN;
                  end else if (LP_WDOG_EN && (r_wdog == LP_WDOG_LAST)) begin
                     r_state <= ST_ERROR;
                  end else begin
                     r_wdog <= r_wdog + 32'd1;
                  end
               end
               ST_DRAIN: begin
                  if (acc.done == 3'd0) begin
                     r_state <= ST_NEXT;
                  end
               end
               ST_NEXT: begin
                  if (r_layer == (r_num_layers - 3'd1)) begin
                     o_finished <= 1'b1;
                     r_state    <= ST_FINISH;
                  end else begin
                     r_layer <= r_layer + 3'd1;
                     r_state <= ST_LOAD;
                  end
               end
               ST_FINISH: begin
                  o_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
               ST_ERROR: begin
                  o_error <= 1'b1;
                  o_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
               default: begin
                  o_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_layer_sequencer
//   Scoreboard bench for layer_sequencer. Each run pushes the expected go and
//   finished events (from a bench-side copy of the descriptor table) into a
//   queue; a monitor pops and compares whenever the DUT pulses go or finished.
//   A simple accelerator model raises done a chosen number of cycles after go.
//   Expected run_cycles come from the per-layer cost: LOAD + ISSUE + WAIT(d)
//   + DRAIN(h) + NEXT per layer, plus one FINISH cycle.
// ---------------------------------------------------------------------------
module tb_layer_sequencer;
   localparam int ML = 4;
   localparam int TO = 50;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_cfg_we;
   logic [2:0]  i_cfg_layer;
   logic [2:0]  i_cfg_field;
   logic [31:0] i_cfg_wdata;
   logic [2:0]  i_num_layers;
   logic        i_start;
   logic        i_abort;
   logic        o_busy;
   logic        o_finished;
   logic        o_error;
   logic [31:0] o_run_cycles;

   layer_sequencer_if ifc ();

   layer_sequencer #(.MAX_LAYERS(ML), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_cfg_we     (i_cfg_we),
      .i_cfg_layer  (i_cfg_layer),
      .i_cfg_field  (i_cfg_field),
      .i_cfg_wdata  (i_cfg_wdata),
      .i_num_layers (i_num_layers),
      .i_start      (i_start),
      .i_abort      (i_abort),
      .o_busy       (o_busy),
      .o_finished   (o_finished),
      .o_error      (o_error),
      .o_run_cycles (o_run_cycles),
      .acc          (ifc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             fin;
      logic [2:0]       idx;
      logic [4:0][31:0] f;
   } ev_t;

   ev_t         exp_q [$];
   logic [31:0] m_tab [0:ML-1][0:4];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          run_active = 1'b0;

   int          cyc = 0;
   int          plan_d [$];
   int          plan_h [$];
   int          cur_d = 0;
   int          cur_h = 0;
   int          go_cyc = 0;
   bit          armed = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Accelerator model: done (random nonzero) during cycles go+d .. go+d+h-1; d==0 means never.
   initial begin
      ifc.done = 3'd0;
      forever begin
         @(negedge clk);
         if (ifc.go === 1'b1) begin
            check("go_while_done", 32'(ifc.done), 32'd0);
            if (plan_d.size() > 0) begin
               cur_d = plan_d.pop_front();
               cur_h = plan_h.pop_front();
            end else begin
               cur_d = 0;
               cur_h = 0;
            end
            go_cyc = cyc;
            armed  = 1'b1;
         end
         if (armed && cur_d != 0 && (cyc - go_cyc) >= cur_d && (cyc - go_cyc) < cur_d + cur_h)
            ifc.done = 3'($urandom_range(1, 7));
         else
            ifc.done = 3'd0;
      end
   end

   // Scoreboard monitor: every go / finished pulse must match the queue head.
   initial begin
      ev_t ev;
      forever begin
         @(negedge clk);
         if (ifc.go === 1'b1) begin
            if (exp_q.size() == 0 || exp_q[0].fin) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_go: layer_index %0d", ifc.layer_index);
            end else begin
               ev = exp_q.pop_front();
               check("go_layer_index", 32'(ifc.layer_index), 32'(ev.idx));
               check("go_data_address", ifc.data_address, ev.f[0]);
               check("go_data_size", ifc.data_size, ev.f[1]);
               check("go_weight_address", ifc.weight_address, ev.f[2]);
               check("go_weight_size", ifc.weight_size, ev.f[3]);
               check("go_result_address", ifc.result_address, ev.f[4]);
            end
         end
         if (o_finished === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0 || !exp_q[0].fin) begin
               n_fail++;
               $display("FAIL unexpected_finished: queue size %0d", exp_q.size());
            end else begin
               ev = exp_q.pop_front();
            end
         end
      end
   end

   task automatic write_cfg(input int layer, input int field, input logic [31:0] data);
      @(negedge clk);
      i_cfg_we    = 1'b1;
      i_cfg_layer = 3'(layer);
      i_cfg_field = 3'(field);
      i_cfg_wdata = data;
      @(negedge clk);
      i_cfg_we = 1'b0;
      if (!run_active && layer < ML && field <= 4) m_tab[layer][field] = data;
   endtask

   task automatic expect_layers(input int n_go, input bit fin);
      ev_t e;
      for (int i = 0; i < n_go; i++) begin
         e     = '0;
         e.idx = 3'(i);
         for (int f = 0; f < 5; f++) e.f[f] = m_tab[i][f];
         exp_q.push_back(e);
      end
      if (fin) begin
         e     = '0;
         e.fin = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_start(input int n, input bit with_abort);
      @(negedge clk);
      i_num_layers = 3'(n);
      i_start      = 1'b1;
      i_abort      = with_abort;
      @(negedge clk);
      i_start = 1'b0;
      i_abort = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (o_busy === 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (o_busy !== 1'b0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_idle_timeout: busy %b after %0d cycles", name, o_busy, k);
      end
   endtask

   task automatic disarm();
      armed = 1'b0;
      plan_d.delete();
      plan_h.delete();
      repeat (3) @(negedge clk);
   endtask

   // Full successful run; dfix/hfix of 0 pick random done delay/hold per layer.
   task automatic run_good(input int n, input int dfix, input int hfix, input string name);
      int exp_rc = 1;
      int d;
      int h;
      plan_d.delete();
      plan_h.delete();
      for (int i = 0; i < n; i++) begin
         d = (dfix != 0) ? dfix : 32'($urandom_range(1, 40));
         h = (hfix != 0) ? hfix : 32'($urandom_range(1, 6));
         plan_d.push_back(d);
         plan_h.push_back(h);
         exp_rc += d + h + 3;
      end
      expect_layers(n, 1'b1);
      run_active = 1'b1;
      pulse_start(n, 1'b0);
      check({name, "_busy"}, 32'(o_busy), 32'd1);
      wait_idle(name);
      run_active = 1'b0;
      check({name, "_error"}, 32'(o_error), 32'd0);
      check({name, "_run_cycles"}, o_run_cycles, 32'(exp_rc));
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int          n;
      int          rc_before;
      int          k;
      logic [31:0] v;

      rst = 1'b1;  i_cfg_we = 1'b0;  i_cfg_layer = 3'd0;  i_cfg_field = 3'd0;
      i_cfg_wdata = 32'd0;  i_num_layers = 3'd0;  i_start = 1'b0;  i_abort = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_finished", 32'(o_finished), 32'd0);
      check("rst_error", 32'(o_error), 32'd0);
      check("rst_go", 32'(ifc.go), 32'd0);
      check("rst_layer_index", 32'(ifc.layer_index), 32'd0);
      check("rst_data_address", ifc.data_address, 32'd0);
      check("rst_run_cycles", o_run_cycles, 32'd0);
      rst = 1'b0;

      // Program every row, then the reference addresses, then some out-of-range writes.
      for (int l = 0; l < ML; l++)
         for (int f = 0; f < 5; f++) write_cfg(l, f, $urandom);
      write_cfg(0, 0, 32'h100);
      write_cfg(1, 0, 32'h200);
      write_cfg(2, 0, 32'h300);
      for (int i = 0; i < 4; i++) write_cfg(int'($urandom_range(0, 3)), int'($urandom_range(5, 7)), $urandom);
      for (int i = 0; i < 4; i++) write_cfg(int'($urandom_range(4, 7)), int'($urandom_range(0, 4)), $urandom);

      run_good(3, 10, 1, "three_layer");

      // Out-of-range layer counts: error, no run, run_cycles frozen.
      rc_before = int'(o_run_cycles);
      pulse_start(0, 1'b0);
      check("num0_busy", 32'(o_busy), 32'd0);
      check("num0_error", 32'(o_error), 32'd1);
      pulse_start(5, 1'b0);
      repeat (3) @(negedge clk);
      check("num5_busy", 32'(o_busy), 32'd0);
      check("num5_error", 32'(o_error), 32'd1);
      check("num_bad_run_cycles", o_run_cycles, 32'(rc_before));

      // start and abort together: no run, error untouched.
      pulse_start(2, 1'b1);
      repeat (3) @(negedge clk);
      check("start_abort_busy", 32'(o_busy), 32'd0);
      check("start_abort_error", 32'(o_error), 32'd1);

      // Watchdog on layer 1.
      plan_d.delete();  plan_h.delete();
      plan_d.push_back(5);  plan_h.push_back(2);
      plan_d.push_back(0);  plan_h.push_back(0);
      expect_layers(2, 1'b0);
      pulse_start(2, 1'b0);
      wait_idle("timeout");
      check("timeout_error", 32'(o_error), 32'd1);
      check("timeout_layer_index", 32'(ifc.layer_index), 32'd1);
      check("timeout_data_address", ifc.data_address, m_tab[1][0]);
      check("timeout_result_address", ifc.result_address, m_tab[1][4]);
      check("timeout_run_cycles", o_run_cycles, 32'd63);
      check("timeout_queue_empty", 32'(exp_q.size()), 32'd0);
      disarm();

      // Abort three cycles into WAIT of layer 1.
      plan_d.delete();  plan_h.delete();
      plan_d.push_back(6);  plan_h.push_back(1);
      plan_d.push_back(30); plan_h.push_back(1);
      expect_layers(2, 1'b0);
      pulse_start(2, 1'b0);
      k = 0;
      while (!(ifc.go === 1'b1 && ifc.layer_index == 3'd1) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("abort_reached_layer1", 32'(ifc.layer_index), 32'd1);
      repeat (3) @(negedge clk);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      check("abort_busy", 32'(o_busy), 32'd0);
      check("abort_finished", 32'(o_finished), 32'd0);
      check("abort_error", 32'(o_error), 32'd0);
      check("abort_run_cycles", o_run_cycles, 32'd15);
      check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
      disarm();
      run_good(2, 0, 0, "after_abort");

      // Descriptor write while busy is dropped.
      plan_d.delete();  plan_h.delete();
      for (int i = 0; i < 3; i++) begin plan_d.push_back(20); plan_h.push_back(1); end
      expect_layers(3, 1'b1);
      run_active = 1'b1;
      pulse_start(3, 1'b0);
      write_cfg(1, 0, 32'hDEAD_BEEF);
      wait_idle("busy_write");
      run_active = 1'b0;
      check("busy_write_queue_empty", 32'(exp_q.size()), 32'd0);
      run_good(2, 0, 0, "rerun");

      run_good(2, 8, 5, "hold5");
      run_good(1, TO, 1, "done_at_expiry");

      // Reset in the middle of a run.
      plan_d.delete();  plan_h.delete();
      plan_d.push_back(20); plan_h.push_back(1);
      expect_layers(1, 1'b0);
      pulse_start(2, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(o_busy), 32'd0);
      check("midrst_layer_index", 32'(ifc.layer_index), 32'd0);
      check("midrst_data_address", ifc.data_address, 32'd0);
      check("midrst_run_cycles", o_run_cycles, 32'd0);
      check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
      disarm();

      // Randomised runs with interleaved table writes.
      for (int it = 0; it < 8; it++) begin
         for (int w = 0; w < 3; w++) begin
            v = $urandom;
            write_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), v);
         end
         n = int'($urandom_range(0, 7));
         if (n >= 1 && n <= ML) begin
            run_good(n, 0, 0, "random_run");
         end else begin
            pulse_start(n, 1'b0);
            repeat (2) @(negedge clk);
            check("random_bad_busy", 32'(o_busy), 32'd0);
            check("random_bad_error", 32'(o_error), 32'd1);
         end
      end

      repeat (5) @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
